// File: rtl/id_stage.sv
// Decode stage of the LA32R five-stage pipeline: latches IF's {inst, pc}, decodes it,
// reads operands, interlocks on RAW hazards and resolves branches back to IF.
module id_stage #(
    parameter int unsigned IF_TO_ID_WIDTH = 64,
    parameter int unsigned ID_TO_EX_WIDTH = 148
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      if_to_id_valid,
    input  logic [IF_TO_ID_WIDTH-1:0] if_to_id_wire,
    output logic                      id_allowin,
    output logic                      br_taken,
    output logic [31:0]               br_target,
    output logic [4:0]                rf_raddr1,
    output logic [4:0]                rf_raddr2,
    input  logic [31:0]               rf_rdata1,
    input  logic [31:0]               rf_rdata2,
    input  logic [4:0]                ex_dest,
    input  logic [4:0]                mem_dest,
    input  logic [4:0]                wb_dest,
    input  logic                      ex_allowin,
    output logic                      id_to_ex_valid,
    output logic [ID_TO_EX_WIDTH-1:0] id_to_ex_wire
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ALU_W  = 12;
    localparam int unsigned REG_AW = 5;

    typedef struct packed {
        logic [ALU_W-1:0]  alu_op;
        logic              res_from_mem;
        logic              mem_we;
        logic              gr_we;
        logic [REG_AW-1:0] dest;
        logic [XLEN-1:0]   rkd_value;
        logic [XLEN-1:0]   src2;
        logic [XLEN-1:0]   src1;
        logic [XLEN-1:0]   pc;
    } id_to_ex_t;

    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] id_inst_q, id_inst_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;

    logic            ready_go;
    logic            cond;
    id_to_ex_t       ex_bus;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid_q <= 1'b0;
            id_inst_q  <= '0;
            id_pc_q    <= '0;
        end else begin
            id_valid_q <= id_valid_d;
            id_inst_q  <= id_inst_d;
            id_pc_q    <= id_pc_d;
        end
    end

    // A bundle arriving alongside a taken branch is the wrong-path fetch: load it invalid.
    always_comb begin
        id_valid_d = id_valid_q;
        id_inst_d  = id_inst_q;
        id_pc_d    = id_pc_q;
        if (id_allowin) begin
            id_valid_d = if_to_id_valid & ~br_taken;
            id_inst_d  = if_to_id_wire[63:32];
            id_pc_d    = if_to_id_wire[31:0];
        end
    end

    logic [16:0]       op_31_15;
    logic [9:0]        op_31_22;
    logic [6:0]        op_31_25;
    logic [5:0]        op_31_26;
    logic [REG_AW-1:0] rd, rj, rk;

    assign op_31_15 = id_inst_q[31:15];
    assign op_31_22 = id_inst_q[31:22];
    assign op_31_25 = id_inst_q[31:25];
    assign op_31_26 = id_inst_q[31:26];
    assign rd       = id_inst_q[4:0];
    assign rj       = id_inst_q[9:5];
    assign rk       = id_inst_q[14:10];

    logic inst_add, inst_sub, inst_slt, inst_sltu, inst_nor, inst_and, inst_or, inst_xor;
    logic inst_slli, inst_srli, inst_srai, inst_addi, inst_ld, inst_st, inst_lu12i;
    logic inst_jirl, inst_b, inst_bl, inst_beq, inst_bne;

    assign inst_add   = op_31_15 == 17'h00020;
    assign inst_sub   = op_31_15 == 17'h00022;
    assign inst_slt   = op_31_15 == 17'h00024;
    assign inst_sltu  = op_31_15 == 17'h00025;
    assign inst_nor   = op_31_15 == 17'h00028;
    assign inst_and   = op_31_15 == 17'h00029;
    assign inst_or    = op_31_15 == 17'h0002A;
    assign inst_xor   = op_31_15 == 17'h0002B;
    assign inst_slli  = op_31_15 == 17'h00081;
    assign inst_srli  = op_31_15 == 17'h00089;
    assign inst_srai  = op_31_15 == 17'h00091;
    assign inst_addi  = op_31_22 == 10'h00A;
    assign inst_ld    = op_31_22 == 10'h0A2;
    assign inst_st    = op_31_22 == 10'h0A6;
    assign inst_lu12i = op_31_25 == 7'h0A;
    assign inst_jirl  = op_31_26 == 6'h13;
    assign inst_b     = op_31_26 == 6'h14;
    assign inst_bl    = op_31_26 == 6'h15;
    assign inst_beq   = op_31_26 == 6'h16;
    assign inst_bne   = op_31_26 == 6'h17;

    logic r_type, shift_imm, si12_type, src2_is_imm, link, rd_as_src2;
    logic use_src1, use_src2, gr_we, haz1, haz2;

    assign r_type      = inst_add | inst_sub | inst_slt | inst_sltu |
                         inst_nor | inst_and | inst_or  | inst_xor;
    assign shift_imm   = inst_slli | inst_srli | inst_srai;
    assign si12_type   = inst_addi | inst_ld | inst_st;
    assign src2_is_imm = si12_type | shift_imm | inst_lu12i;
    assign link        = inst_bl | inst_jirl;
    assign rd_as_src2  = inst_st | inst_beq | inst_bne;
    assign gr_we       = r_type | shift_imm | inst_addi | inst_ld | inst_lu12i | link;

    assign rf_raddr1 = rj;
    assign rf_raddr2 = rd_as_src2 ? rd : rk;

    logic [XLEN-1:0] imm, offs16, offs26;

    assign offs16 = {{14{id_inst_q[25]}}, id_inst_q[25:10], 2'b00};
    assign offs26 = {{4{id_inst_q[9]}}, id_inst_q[9:0], id_inst_q[25:10], 2'b00};

    always_comb begin
        imm = {{20{id_inst_q[21]}}, id_inst_q[21:10]};
        if (shift_imm)  imm = XLEN'(rk);
        if (inst_lu12i) imm = {id_inst_q[24:5], 12'h000};
    end

    // RAW interlock: a nonzero source still pending in EX/MEM/WB stalls the stage.
    assign use_src1 = ~(inst_b | inst_bl | inst_lu12i);
    assign use_src2 = r_type | rd_as_src2;
    assign haz1     = use_src1 && (rf_raddr1 != '0) &&
                      (rf_raddr1 == ex_dest || rf_raddr1 == mem_dest || rf_raddr1 == wb_dest);
    assign haz2     = use_src2 && (rf_raddr2 != '0) &&
                      (rf_raddr2 == ex_dest || rf_raddr2 == mem_dest || rf_raddr2 == wb_dest);
    assign ready_go = ~(haz1 | haz2);

    assign id_allowin     = ~id_valid_q | (ready_go & ex_allowin);
    assign id_to_ex_valid = id_valid_q & ready_go;

    assign cond      = inst_b | inst_bl | inst_jirl |
                       (inst_beq & (rf_rdata1 == rf_rdata2)) |
                       (inst_bne & (rf_rdata1 != rf_rdata2));
    assign br_taken  = id_valid_q & ready_go & ex_allowin & cond;
    assign br_target = (inst_jirl ? rf_rdata1 : id_pc_q) +
                       ((inst_b | inst_bl) ? offs26 : offs16);

    logic [REG_AW-1:0] dest_raw;
    assign dest_raw = inst_bl ? REG_AW'(1) : rd;

    always_comb begin
        ex_bus              = '0;
        ex_bus.alu_op[0]    = ~(inst_sub | inst_slt | inst_sltu | inst_and | inst_nor |
                                inst_or | inst_xor | inst_slli | inst_srli | inst_srai |
                                inst_lu12i);
        ex_bus.alu_op[1]    = inst_sub;
        ex_bus.alu_op[2]    = inst_slt;
        ex_bus.alu_op[3]    = inst_sltu;
        ex_bus.alu_op[4]    = inst_and;
        ex_bus.alu_op[5]    = inst_nor;
        ex_bus.alu_op[6]    = inst_or;
        ex_bus.alu_op[7]    = inst_xor;
        ex_bus.alu_op[8]    = inst_slli;
        ex_bus.alu_op[9]    = inst_srli;
        ex_bus.alu_op[10]   = inst_srai;
        ex_bus.alu_op[11]   = inst_lu12i;
        ex_bus.res_from_mem = inst_ld;
        ex_bus.mem_we       = inst_st;
        ex_bus.gr_we        = gr_we;
        ex_bus.dest         = (gr_we && dest_raw != '0) ? dest_raw : '0;
        ex_bus.rkd_value    = rf_rdata2;
        ex_bus.src2         = link ? XLEN'(4) : (src2_is_imm ? imm : rf_rdata2);
        ex_bus.src1         = link ? id_pc_q : rf_rdata1;
        ex_bus.pc           = id_pc_q;
    end

    assign id_to_ex_wire = ex_bus;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode fields, RAW interlock, branch resolution,
// backpressure and asynchronous reset, against hand-computed expectations.
module tb_id_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         if_to_id_valid;
    logic [63:0]  if_to_id_wire;
    logic         id_allowin;
    logic         br_taken;
    logic [31:0]  br_target;
    logic [4:0]   rf_raddr1, rf_raddr2;
    logic [31:0]  rf_rdata1, rf_rdata2;
    logic [4:0]   ex_dest, mem_dest, wb_dest;
    logic         ex_allowin;
    logic         id_to_ex_valid;
    logic [147:0] id_to_ex_wire;

    int n_checks = 0;
    int n_fail   = 0;

    id_stage dut (
        .clk            (clk),
        .reset          (reset),
        .if_to_id_valid (if_to_id_valid),
        .if_to_id_wire  (if_to_id_wire),
        .id_allowin     (id_allowin),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .rf_raddr1      (rf_raddr1),
        .rf_raddr2      (rf_raddr2),
        .rf_rdata1      (rf_rdata1),
        .rf_rdata2      (rf_rdata2),
        .ex_dest        (ex_dest),
        .mem_dest       (mem_dest),
        .wb_dest        (wb_dest),
        .ex_allowin     (ex_allowin),
        .id_to_ex_valid (id_to_ex_valid),
        .id_to_ex_wire  (id_to_ex_wire)
    );

    always #5 clk = ~clk;

    logic [11:0] o_alu;
    logic        o_rfm, o_mwe, o_gwe;
    logic [4:0]  o_dest;
    logic [31:0] o_rkd, o_src2, o_src1, o_pc;

    assign o_alu  = id_to_ex_wire[147:136];
    assign o_rfm  = id_to_ex_wire[135];
    assign o_mwe  = id_to_ex_wire[134];
    assign o_gwe  = id_to_ex_wire[133];
    assign o_dest = id_to_ex_wire[132:128];
    assign o_rkd  = id_to_ex_wire[127:96];
    assign o_src2 = id_to_ex_wire[95:64];
    assign o_src1 = id_to_ex_wire[63:32];
    assign o_pc   = id_to_ex_wire[31:0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one bundle from IF for a single edge, then withdraw it.
    task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
        if_to_id_valid = 1'b1;
        if_to_id_wire  = {inst, pc};
        tick();
        if_to_id_valid = 1'b0;
        if_to_id_wire  = 64'h0;
    endtask

    initial begin
        reset          = 1'b1;
        if_to_id_valid = 1'b0;
        if_to_id_wire  = 64'h0;
        rf_rdata1      = 32'd10;
        rf_rdata2      = 32'd20;
        ex_dest        = 5'd0;
        mem_dest       = 5'd0;
        wb_dest        = 5'd0;
        ex_allowin     = 1'b1;
        tick();
        chk("rst_allowin", 32'(id_allowin), 32'd1);
        chk("rst_br_taken", 32'(br_taken), 32'd0);
        chk("rst_valid", 32'(id_to_ex_valid), 32'd0);
        reset = 1'b0;

        // addi.w r1,r1,3
        issue(32'h02800C21, 32'h1C000000);
        chk("addi_valid", 32'(id_to_ex_valid), 32'd1);
        chk("addi_src2", o_src2, 32'd3);
        chk("addi_dest", 32'(o_dest), 32'd1);
        chk("addi_alu", 32'(o_alu), 32'h001);
        chk("addi_src1", o_src1, 32'd10);
        chk("addi_pc", o_pc, 32'h1C000000);
        chk("addi_gr_we", 32'(o_gwe), 32'd1);

        // add.w r2,r1,r3 with r1 pending in EX
        issue(32'h00100C22, 32'h1C000004);
        ex_dest = 5'd1;
        #1;
        chk("haz_ex_valid", 32'(id_to_ex_valid), 32'd0);
        chk("haz_ex_allowin", 32'(id_allowin), 32'd0);
        chk("add_raddr2", 32'(rf_raddr2), 32'd3);
        tick();
        chk("haz_hold_pc", o_pc, 32'h1C000004);
        chk("haz_hold_valid", 32'(id_to_ex_valid), 32'd0);
        ex_dest  = 5'd0;
        mem_dest = 5'd3;
        #1;
        chk("haz_mem_rk", 32'(id_to_ex_valid), 32'd0);
        mem_dest = 5'd0;
        wb_dest  = 5'd0;
        #1;
        chk("add_issue", 32'(id_to_ex_valid), 32'd1);
        chk("add_dest", 32'(o_dest), 32'd2);
        chk("add_src2", o_src2, 32'd20);
        tick();
        chk("add_drained", 32'(id_to_ex_valid), 32'd0);

        // beq r4,r5,+16 at 0x1C000010 with a wrong-path fetch alongside
        issue(32'h58001085, 32'h1C000010);
        rf_rdata1 = 32'd7;
        rf_rdata2 = 32'd8;
        #1;
        chk("beq_ne_taken", 32'(br_taken), 32'd0);
        rf_rdata2 = 32'd7;
        if_to_id_valid = 1'b1;
        if_to_id_wire  = {32'h02800C21, 32'h1C000014};
        #1;
        chk("beq_taken", 32'(br_taken), 32'd1);
        chk("beq_target", br_target, 32'h1C000020);
        chk("beq_raddr1", 32'(rf_raddr1), 32'd4);
        chk("beq_raddr2", 32'(rf_raddr2), 32'd5);
        chk("beq_dest", 32'(o_dest), 32'd0);
        tick();
        if_to_id_valid = 1'b0;
        chk("beq_squash", 32'(id_to_ex_valid), 32'd0);
        chk("beq_squash_br", 32'(br_taken), 32'd0);

        // bl -4 at 0x1C000100; r31 pending must not stall it
        issue(32'h57FFFFFF, 32'h1C000100);
        ex_dest = 5'd31;
        #1;
        chk("bl_valid", 32'(id_to_ex_valid), 32'd1);
        chk("bl_taken", 32'(br_taken), 32'd1);
        chk("bl_target", br_target, 32'h1C0000FC);
        chk("bl_dest", 32'(o_dest), 32'd1);
        chk("bl_src1", o_src1, 32'h1C000100);
        chk("bl_src2", o_src2, 32'd4);
        ex_dest = 5'd0;
        tick();

        // jirl r1,r6,+32 held by EX backpressure
        rf_rdata1 = 32'h1C001000;
        issue(32'h4C0020C1, 32'h1C000200);
        ex_allowin = 1'b0;
        #1;
        chk("jirl_stall_br", 32'(br_taken), 32'd0);
        chk("jirl_stall_allowin", 32'(id_allowin), 32'd0);
        tick();
        chk("jirl_hold_br", 32'(br_taken), 32'd0);
        chk("jirl_hold_pc", o_pc, 32'h1C000200);
        ex_allowin = 1'b1;
        #1;
        chk("jirl_taken", 32'(br_taken), 32'd1);
        chk("jirl_target", br_target, 32'h1C001020);
        chk("jirl_dest", 32'(o_dest), 32'd1);
        tick();
        chk("jirl_pulse_end", 32'(br_taken), 32'd0);

        // ld.w r7,r2,-4 / lu12i.w r3,0x12345 / srai.w r1,r2,31 / st.w r7,r2,-4
        issue(32'h28BFF047, 32'h1C000300);
        chk("ld_src2", o_src2, 32'hFFFFFFFC);
        chk("ld_rfm", 32'(o_rfm), 32'd1);
        chk("ld_dest", 32'(o_dest), 32'd7);
        issue(32'h142468A3, 32'h1C000304);
        chk("lui_src2", o_src2, 32'h12345000);
        chk("lui_alu", 32'(o_alu), 32'h800);
        issue(32'h0048FC41, 32'h1C000308);
        chk("srai_src2", o_src2, 32'd31);
        chk("srai_alu", 32'(o_alu), 32'h400);
        issue(32'h29BFF047, 32'h1C00030C);
        chk("st_mem_we", 32'(o_mwe), 32'd1);
        chk("st_dest", 32'(o_dest), 32'd0);
        chk("st_raddr2", 32'(rf_raddr2), 32'd7);

        // reset asserted mid-stall
        issue(32'h00100C22, 32'h1C000400);
        ex_dest = 5'd1;
        #1;
        chk("pre_rst_allowin", 32'(id_allowin), 32'd0);
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(id_to_ex_valid), 32'd0);
        chk("async_rst_allowin", 32'(id_allowin), 32'd1);
        #1;
        reset   = 1'b0;
        ex_dest = 5'd0;

        // unlisted encoding decodes as NOP
        issue(32'hFFFFFFFF, 32'h1C000500);
        chk("nop_valid", 32'(id_to_ex_valid), 32'd1);
        chk("nop_gr_we", 32'(o_gwe), 32'd0);
        chk("nop_dest", 32'(o_dest), 32'd0);
        chk("nop_alu", 32'(o_alu), 32'h001);
        chk("nop_br", 32'(br_taken), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage LA32R pipeline, between the IF stage and the EX stage. It latches the `{inst, pc}` word handed over by IF and decodes it. It reads two operands from the external register file and interlocks on read-after-write hazards. It resolves every branch and jump in ID, driving `br_taken`/`br_target` back to IF, and passes a fully decoded bundle to EX under a valid/allowin handshake.

## Interface
- `IF_TO_ID_WIDTH`, 64: input bundle; `[63:32]` inst, `[31:0]` pc.
- `ID_TO_EX_WIDTH`, 148: output bundle, MSB→LSB:
  - `alu_op[11:0]`
  - `res_from_mem`
  - `mem_we`
  - `gr_we`
  - `dest[4:0]`
  - `rkd_value[31:0]`
  - `src2[31:0]`
  - `src1[31:0]`
  - `pc[31:0]`
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `if_to_id_valid` in 1: IF holds a valid instruction.
- `if_to_id_wire` in `IF_TO_ID_WIDTH`: instruction bundle from IF.
- `id_allowin` out 1: ID accepts a new bundle this cycle.
- `br_taken` out 1: redirect IF this cycle.
- `br_target` out 32: redirect address.
- `rf_raddr1` out 5: register-file read address 1.
- `rf_raddr2` out 5: register-file read address 2.
- `rf_rdata1` in 32: combinational read data 1.
- `rf_rdata2` in 32: combinational read data 2.
- `ex_dest` in 5: pending write register in EX; 0 = none.
- `mem_dest` in 5: pending write register in MEM; 0 = none.
- `wb_dest` in 5: pending write register in WB; 0 = none.
- `ex_allowin` in 1: EX accepts a bundle.
- `id_to_ex_valid` out 1: bundle valid to EX.
- `id_to_ex_wire` out `ID_TO_EX_WIDTH`: decoded bundle.

## Operation
- State registers:
  - `id_valid`, reset 0.
  - `id_inst`, reset 0.
  - `id_pc`, reset 0.
- Outputs at reset: `id_allowin`=1, `br_taken`=0, `id_to_ex_valid`=0.
- Handshake:
  - `id_allowin = ~id_valid | (ready_go & ex_allowin)`.
  - `id_to_ex_valid = id_valid & ready_go`.
- Load rule: when `id_allowin`:
  - `id_valid <= if_to_id_valid & ~br_taken`.
  - `id_inst`/`id_pc` load from `if_to_id_wire`.
  - This drops the sequential instruction fetched behind a taken branch.
- Decoded subset and opcode fields:
  - `[31:15]`: add.w 0x20, sub.w 0x22, slt 0x24, sltu 0x25, nor 0x28, and 0x29, or 0x2A, xor 0x2B, slli.w 0x81, srli.w 0x89, srai.w 0x91.
  - `[31:22]`: addi.w 0x00A, ld.w 0x0A2, st.w 0x0A6.
  - `[31:25]`: lu12i.w 0x0A.
  - `[31:26]`: jirl 0x13, b 0x14, bl 0x15, beq 0x16, bne 0x17.
- Unlisted encodings decode as NOP: `gr_we`=`mem_we`=`res_from_mem`=0, `alu_op`=add.
- `alu_op` is one-hot: [0] add, [1] sub, [2] slt, [3] sltu, [4] and, [5] nor, [6] or, [7] xor, [8] sll, [9] srl, [10] sra, [11] lui.
- Read addresses:
  - `rf_raddr1` = rj `[9:5]`.
  - `rf_raddr2` = rd `[4:0]` for st.w/beq/bne, else rk `[14:10]`.
- Immediates:
  - si12 `[21:10]` sign-extended: addi/ld/st.
  - ui5 `[14:10]` zero-extended: shifts.
  - `{[24:5],12'b0}`: lu12i.
  - offs16 `[25:10]`: beq/bne/jirl.
  - offs26 `{[9:0],[25:10]}`: b/bl.
  - Branch offsets are shifted left 2 and sign-extended.
- Operands:
  - `src1` = `id_pc` for bl/jirl, else `rf_rdata1`.
  - `src2` = 4 for bl/jirl, immediate for imm-class instructions, else `rf_rdata2`.
  - `rkd_value` = `rf_rdata2`.
- Destination:
  - bl: `dest` = 1.
  - Otherwise `dest` = rd.
  - `gr_we` = 0 for st/beq/bne/b/NOP.
  - `dest` forced to 0 whenever `gr_we` = 0 or rd = 0.
- Hazard:
  - src1 is used by all except b/bl/lu12i.
  - src2 is used by R-type, st.w, beq and bne.
  - `ready_go = 0` when a used source address is ≠0 and equals `ex_dest`, `mem_dest` or `wb_dest`.
- Branch:
  - `cond` = b|bl|jirl | (beq & rdata1==rdata2) | (bne & rdata1!=rdata2).
  - `br_taken = id_valid & ready_go & ex_allowin & cond`.
  - `br_target` = `rf_rdata1` + offs16<<2 for jirl, else `id_pc` + offset.

## Timing
- 1-cycle stage: a bundle accepted at edge N is presented to EX in cycle N+1 if `ready_go` and `ex_allowin` are high.
- `br_taken` is combinational and asserted only in the cycle the branch leaves ID. IF redirects at that same edge, and the bundle loaded at that edge is squashed.
- A stalled branch (hazard or `~ex_allowin`) keeps `br_taken`=0 and holds `id_inst`.
- `ex_allowin` low with `ready_go` high: hold all registers, `id_allowin`=0.
- Async `reset` mid-operation: `id_valid` clears immediately and outputs return to reset values within the same cycle.

## Test plan
- Reset, then `inst`=0x02800C21 (addi.w r1,r1,3), pc=0x1C000000:
  - Next cycle: `id_to_ex_valid`=1, `src2`=3, `dest`=1, `alu_op`=0x001.
- `ex_dest`=1 while ID holds add.w r2,r1,r3:
  - `id_to_ex_valid`=0 and `id_allowin`=0.
  - Clear `ex_dest` → issues next cycle.
- beq r4,r5 offs16=4 at pc 0x1C000010 with rdata1==rdata2, `ex_allowin`=1:
  - `br_taken`=1, target 0x1C000020.
  - A concurrent `if_to_id_valid` bundle is dropped (`id_valid`=0 next).
- bl offs26=-1 at 0x1C000100:
  - `br_target`=0x1C0000FC, `dest`=1, `src1`=0x1C000100, `src2`=4.
- jirl taken while `ex_allowin`=0:
  - `br_taken`=0 until `ex_allowin`=1, then a single-cycle `br_taken` pulse.
- Assert `reset` mid-stall:
  - `id_to_ex_valid` drops asynchronously, `id_allowin`=1.
  - Unlisted opcode 0xFFFFFFFF decodes as NOP with `gr_we`=0 and `dest`=0.
